// File: rtl/led_flash_scheduler.sv
// led_flash_scheduler
// Queues LED colour commands written by the processor and plays them back.
// Each command produces one flash: the selected LED is lit for ON_CYCLES
// clocks, then every LED is dark for GAP_CYCLES clocks.
// A write with bit 2 set flushes the scheduler instead of queueing a colour.
// DEPTH must be a power of two >= 2, so the FIFO pointers wrap naturally.
// ON_CYCLES and GAP_CYCLES must each be >= 1.
module led_flash_scheduler #(
    parameter int DEPTH      = 8,
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        red_led,
    output logic        blue_led,
    output logic        green_led,
    output logic        yellow_led,
    output logic [31:0] status
);

    localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int PW         = $clog2(DEPTH);
    localparam int LW         = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] ON_LOAD   = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } state_t;

    // Command FIFO
    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          overflow;

    // Flash sequencer
    state_t        state;
    logic [CW-1:0] count;
    logic [3:0]    leds;   // {yellow, green, blue, red}

    logic          full;
    logic          flush;
    logic          write_color;
    logic          push;
    logic          pop;
    logic          unused_wr_bits;

    // Upper store-data bits carry no meaning for this register.
    assign unused_wr_bits = ^wr_data[31:3];

    assign full        = (level == DEPTH_LVL);
    assign flush       = wr_en & wr_data[2];
    assign write_color = wr_en & ~wr_data[2];
    // A write that finds the queue full is dropped even if a pop frees a slot
    // on the same edge, so acceptance depends only on the pre-edge level.
    assign push        = write_color & ~full;
    // The sequencer takes a new entry when idle, or when a gap ends.
    // Flush overrides both the pop and the push.
    assign pop         = ~flush & (level != '0) &
                         ((state == IDLE) | ((state == GAP) & (count == '0)));

    // Colour storage: written on accepted pushes only.
    // NOTE: the storage array has no reset; pointers and level define which
    // entries are valid, so resetting the data would only cost logic.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= wr_data[1:0];
        end
    end

    // FIFO pointers, fill level and sticky overflow flag.
    // NOTE: all state registers use non-blocking assignments so every register
    // samples pre-edge values, regardless of statement or block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (write_color && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Flash sequencer: IDLE -> ON (ON_CYCLES) -> GAP (GAP_CYCLES) -> ON or IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
            leds  <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
            leds  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        leds  <= 4'b0001 << mem[rd_ptr];
                        count <= ON_LOAD;
                        state <= ON;
                    end
                end
                ON: begin
                    if (count == '0) begin
                        leds  <= '0;
                        count <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                GAP: begin
                    if (count == '0) begin
                        if (pop) begin
                            leds  <= 4'b0001 << mem[rd_ptr];
                            count <= ON_LOAD;
                            state <= ON;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    leds  <= '0;
                end
            endcase
        end
    end

    assign red_led    = leds[0];
    assign blue_led   = leds[1];
    assign green_led  = leds[2];
    assign yellow_led = leds[3];

    assign status = {24'b0, 4'(level), 1'b0, overflow, full,
                     (state != IDLE) | (level != '0)};

endmodule
